// File: rtl/psiso_arb_ctrl.sv
// Arbitrates N_REQ requesters onto one parallel-in/serial-out shifter and frames the serial bits.
// Define PSISO_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module psiso_arb_ctrl #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 4,
    parameter int unsigned GAP   = 1,
    parameter logic        FILL  = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*WIDTH-1:0]     data,
    output logic [N_REQ-1:0]           ack,
    output logic                       piso_load,
    output logic [WIDTH-1:0]           piso_din,
    output logic                       piso_sin,
    output logic                       ser_valid,
    output logic                       ser_last,
    output logic [$clog2(N_REQ)-1:0]   gnt_id,
    output logic                       busy,
    output logic                       frame_done
);

    localparam int unsigned ID_W    = $clog2(N_REQ);
    localparam int unsigned CNT_MAX = (WIDTH > GAP) ? WIDTH : GAP;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_GAP   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ID_W-1:0]    gid_q, gid_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic               load_q, load_d;
    logic [WIDTH-1:0]   din_q, din_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic               done_q, done_d;

    logic               win_found;
    logic [ID_W-1:0]    win_id;
    logic [WIDTH-1:0]   win_word;

    // First requesting index scanning upward from the pointer with wrap.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            if (!win_found && req[(int'(ptr_q) + k) % int'(N_REQ)]) begin
                win_found = 1'b1;
                win_id    = ID_W'((int'(ptr_q) + k) % int'(N_REQ));
            end
        end
        win_word = data[int'(win_id)*int'(WIDTH) +: WIDTH];
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gid_d   = gid_q;
        ack_d   = '0;
        load_d  = 1'b0;
        din_d   = din_q;
        valid_d = 1'b0;
        last_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d = S_LOAD;
                    gid_d   = win_id;
                    din_d   = win_word;
                    ack_d   = N_REQ'(1) << win_id;
                    load_d  = 1'b1;
                end
            end
            S_LOAD: begin
                state_d = S_SHIFT;
                cnt_d   = '0;
                valid_d = 1'b1;
                last_d  = (WIDTH == 1);
`ifdef PSISO_ARB_FIXED_PRIO_EN
                ptr_d   = '0;
`else
                ptr_d   = ID_W'((int'(gid_q) + 1) % int'(N_REQ));
`endif
            end
            S_SHIFT: begin
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = (GAP > 0) ? S_GAP : S_IDLE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    valid_d = 1'b1;
                    last_d  = (cnt_q + CNT_W'(1)) == CNT_W'(WIDTH - 1);
                end
            end
            S_GAP: begin
                if (cnt_q == CNT_W'(GAP - 1)) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gid_q   <= '0;
            ack_q   <= '0;
            load_q  <= 1'b0;
            din_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gid_q   <= gid_d;
            ack_q   <= ack_d;
            load_q  <= load_d;
            din_q   <= din_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    assign ack        = ack_q;
    assign piso_load  = load_q;
    assign piso_din   = din_q;
    assign piso_sin   = FILL;
    assign ser_valid  = valid_q;
    assign ser_last   = last_q;
    assign gnt_id     = gid_q;
    assign frame_done = done_q;
    assign busy       = (state_q != S_IDLE);

endmodule
